// File: rtl/softex_fp_vect_framer_if.sv
// Valid/ready stream of VECT_WIDTH FP lanes with per-lane strobes.
// The master drives the payload and the slave returns ready.
interface softex_fp_vect_framer_if #(
  parameter int unsigned WIDTH      = 32,
  parameter int unsigned VECT_WIDTH = 1
);
  logic                        valid;
  logic                        ready;
  logic [VECT_WIDTH*WIDTH-1:0] vect;
  logic [VECT_WIDTH-1:0]       strb;

  modport master (output valid, vect, strb, input ready);
  modport slave  (input valid, vect, strb, output ready);
endinterface

// File: rtl/softex_fp_vect_framer.sv
// Frames raw FP beats into one softmax row: masks lanes past the row end, tags the
// final beat, counts strobed elements and decouples ready through a 2-entry FIFO.
module softex_fp_vect_framer #(
  parameter int unsigned FPFORMAT   = 0,
  parameter int unsigned VECT_WIDTH = 1,
  parameter int unsigned LEN_WIDTH  = 16
) (
  input  logic                   clk_i,
  input  logic                   rst_i,
  input  logic                   clear_i,
  input  logic                   start_i,
  input  logic [LEN_WIDTH-1:0]   length_i,
  output logic                   busy_o,
  output logic                   done_o,
  softex_fp_vect_framer_if.slave  in_s,
  softex_fp_vect_framer_if.master out_m,
  output logic                   out_last_o,
  output logic [LEN_WIDTH-1:0]   elem_cnt_o
);

  // Element width for the fpnew format encoding (FP32, FP64, FP16, FP8, FP16ALT).
  function automatic int unsigned fp_width(input int unsigned fmt);
    case (fmt)
      0:       fp_width = 32;
      1:       fp_width = 64;
      2:       fp_width = 16;
      3:       fp_width = 8;
      4:       fp_width = 16;
      default: fp_width = 32;
    endcase
  endfunction

  localparam int unsigned WIDTH = fp_width(FPFORMAT);
  localparam int unsigned DW    = VECT_WIDTH * WIDTH;

  function automatic logic [LEN_WIDTH:0] popcount(input logic [VECT_WIDTH-1:0] v);
    popcount = '0;
    for (int i = 0; i < VECT_WIDTH; i++) begin
      popcount = popcount + (LEN_WIDTH+1)'(v[i]);
    end
  endfunction

  typedef enum logic [1:0] {IDLE = 2'd0, RUN = 2'd1, DRAIN = 2'd2, DONE = 2'd3} state_e;

  state_e                  state_q, state_d;
  logic [LEN_WIDTH-1:0]    rem_q, rem_d;
  logic [LEN_WIDTH-1:0]    cnt_q, cnt_d;
  logic                    hd_vld_q, hd_vld_d, tl_vld_q, tl_vld_d;
  logic                    hd_last_q, hd_last_d, tl_last_q, tl_last_d;
  logic [DW-1:0]           hd_vect_q, hd_vect_d, tl_vect_q, tl_vect_d;
  logic [VECT_WIDTH-1:0]   hd_strb_q, hd_strb_d, tl_strb_q, tl_strb_d;

  logic                    in_ready_s, push_s, pop_s, last_s;
  logic [VECT_WIDTH-1:0]   lane_mask_s, strb_m_s;
  logic [LEN_WIDTH:0]      cnt_sum_s;

  // The tail slot is only ever occupied behind a valid head, so tail valid means full.
  assign in_ready_s = (state_q == RUN) && !tl_vld_q;
  assign push_s     = in_s.valid && in_ready_s;
  assign pop_s      = hd_vld_q && out_m.ready;

  // Beat framing, element counting, FIFO movement and next FSM state.
  always_comb begin
    state_d   = state_q;
    rem_d     = rem_q;
    cnt_d     = cnt_q;
    hd_vld_d  = hd_vld_q;
    hd_last_d = hd_last_q;
    hd_vect_d = hd_vect_q;
    hd_strb_d = hd_strb_q;
    tl_vld_d  = tl_vld_q;
    tl_last_d = tl_last_q;
    tl_vect_d = tl_vect_q;
    tl_strb_d = tl_strb_q;

    // Lane k is inside the row iff k < min(rem, VECT_WIDTH), i.e. k < rem.
    for (int k = 0; k < VECT_WIDTH; k++) begin
      lane_mask_s[k] = (LEN_WIDTH'(k) < rem_q);
    end
    strb_m_s  = in_s.strb & lane_mask_s;
    last_s    = (rem_q <= LEN_WIDTH'(VECT_WIDTH));
    cnt_sum_s = {1'b0, cnt_q} + popcount(strb_m_s);

    if (push_s) begin
      rem_d = last_s ? '0 : rem_q - LEN_WIDTH'(VECT_WIDTH);
      if (cnt_sum_s[LEN_WIDTH]) begin
        cnt_d = '1;
      end else begin
        cnt_d = cnt_sum_s[LEN_WIDTH-1:0];
      end
    end else begin
      rem_d = rem_q;
    end

    if (tl_vld_q) begin
      if (pop_s) begin
        hd_vect_d = tl_vect_q;
        hd_strb_d = tl_strb_q;
        hd_last_d = tl_last_q;
        tl_vld_d  = 1'b0;
      end else begin
        tl_vld_d  = 1'b1;
      end
    end else if (hd_vld_q) begin
      if (push_s && !pop_s) begin
        tl_vld_d  = 1'b1;
        tl_vect_d = in_s.vect;
        tl_strb_d = strb_m_s;
        tl_last_d = last_s;
      end else if (push_s) begin
        hd_vect_d = in_s.vect;
        hd_strb_d = strb_m_s;
        hd_last_d = last_s;
      end else begin
        hd_vld_d  = !pop_s;
      end
    end else begin
      if (push_s) begin
        hd_vld_d  = 1'b1;
        hd_vect_d = in_s.vect;
        hd_strb_d = strb_m_s;
        hd_last_d = last_s;
      end else begin
        hd_vld_d  = 1'b0;
      end
    end

    case (state_q)
      IDLE: begin
        if (start_i) begin
          cnt_d = '0;
          if (length_i != '0) begin
            rem_d   = length_i;
            state_d = RUN;
          end else begin
            state_d = DONE;
          end
        end else begin
          state_d = IDLE;
        end
      end
      RUN: begin
        if (push_s && last_s) begin
          state_d = DRAIN;
        end else begin
          state_d = RUN;
        end
      end
      DRAIN: begin
        if (pop_s && hd_last_q) begin
          state_d = DONE;
        end else begin
          state_d = DRAIN;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // State registers; reset and clear both return to an empty, idle framer.
  always_ff @(posedge clk_i) begin
    if (rst_i || clear_i) begin
      state_q   <= IDLE;
      rem_q     <= '0;
      cnt_q     <= '0;
      hd_vld_q  <= 1'b0;
      hd_last_q <= 1'b0;
      hd_vect_q <= '0;
      hd_strb_q <= '0;
      tl_vld_q  <= 1'b0;
      tl_last_q <= 1'b0;
      tl_vect_q <= '0;
      tl_strb_q <= '0;
    end else begin
      state_q   <= state_d;
      rem_q     <= rem_d;
      cnt_q     <= cnt_d;
      hd_vld_q  <= hd_vld_d;
      hd_last_q <= hd_last_d;
      hd_vect_q <= hd_vect_d;
      hd_strb_q <= hd_strb_d;
      tl_vld_q  <= tl_vld_d;
      tl_last_q <= tl_last_d;
      tl_vect_q <= tl_vect_d;
      tl_strb_q <= tl_strb_d;
    end
  end

  assign busy_o      = (state_q != IDLE);
  assign done_o      = (state_q == DONE);
  assign in_s.ready  = in_ready_s;
  assign out_m.valid = hd_vld_q;
  assign out_m.vect  = hd_vect_q;
  assign out_m.strb  = hd_strb_q;
  assign out_last_o  = hd_last_q;
  assign elem_cnt_o  = cnt_q;

endmodule

// File: tb/tb_softex_fp_vect_framer.sv
// Directed bench for softex_fp_vect_framer with VECT_WIDTH=4 FP32 lanes.
module tb_softex_fp_vect_framer;
  localparam int VW = 4;
  localparam int W  = 32;
  localparam int LW = 16;

  logic          clk = 1'b0;
  logic          rst_i, clear_i, start_i, busy_o, done_o, out_last_o;
  logic [LW-1:0] length_i, elem_cnt_o;

  softex_fp_vect_framer_if #(.WIDTH(W), .VECT_WIDTH(VW)) in_if ();
  softex_fp_vect_framer_if #(.WIDTH(W), .VECT_WIDTH(VW)) out_if ();

  softex_fp_vect_framer #(.FPFORMAT(0), .VECT_WIDTH(VW), .LEN_WIDTH(LW)) dut (
    .clk_i(clk), .rst_i(rst_i), .clear_i(clear_i), .start_i(start_i), .length_i(length_i),
    .busy_o(busy_o), .done_o(done_o), .in_s(in_if.slave), .out_m(out_if.master),
    .out_last_o(out_last_o), .elem_cnt_o(elem_cnt_o)
  );

  always #5 clk = ~clk;

  int n_chk = 0;
  int n_bad = 0;
  int cyc = 0;
  int acc_cnt, done_cnt, busy_cnt, done_cyc;
  logic [VW*W-1:0] oq_vect[$];
  logic [VW-1:0]   oq_strb[$];
  logic            oq_last[$];
  int              oq_cyc[$];

  task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic logic [VW*W-1:0] beat_data(input int row, input int b);
    logic [VW*W-1:0] r;
    for (int k = 0; k < VW; k++) r[k*W +: W] = {8'(row), 8'(b), 8'(k), 8'h5A};
    return r;
  endfunction

  always @(posedge clk) cyc <= cyc + 1;

  // Observe handshakes mid-cycle, away from the active edge.
  always @(negedge clk) begin
    if (in_if.valid && in_if.ready) acc_cnt++;
    if (out_if.valid && out_if.ready) begin
      oq_vect.push_back(out_if.vect);
      oq_strb.push_back(out_if.strb);
      oq_last.push_back(out_last_o);
      oq_cyc.push_back(cyc);
    end
    if (done_o) begin
      done_cnt++;
      done_cyc = cyc;
    end
    if (busy_o) busy_cnt++;
  end

  task automatic clear_mon();
    acc_cnt = 0; done_cnt = 0; busy_cnt = 0; done_cyc = -1;
    oq_vect.delete(); oq_strb.delete(); oq_last.delete(); oq_cyc.delete();
  endtask

  task automatic tick();
    @(posedge clk); #1;
  endtask

  // Run one row: hold out_ready low for the first 'hold' cycles, optionally re-pulse start mid-row.
  task automatic run_row(input int len, input logic [VW-1:0] strb, input int row,
                         input int restart_len, input int hold);
    logic [VW*W-1:0] held;
    clear_mon();
    start_i = 1'b1; length_i = LW'(len); in_if.valid = 1'b0;
    tick();
    start_i = 1'b0;
    held = '0;
    for (int it = 0; it < 80; it++) begin
      in_if.valid = 1'b1;
      in_if.vect  = beat_data(row, acc_cnt);
      in_if.strb  = strb;
      out_if.ready = (it >= hold);
      if (it == 1 && restart_len > 0) begin
        start_i = 1'b1; length_i = LW'(restart_len);
      end else begin
        start_i = 1'b0;
      end
      if (it == 2 && hold > 0) held = out_if.vect;
      if (it == hold - 1 && hold > 0) begin
        chk("hold_acc", acc_cnt, 2);
        chk("hold_in_ready", in_if.ready, 1'b0);
        chk("hold_out_valid", out_if.valid, 1'b1);
        chk("hold_head_b0", out_if.vect, beat_data(row, 0));
        chk("hold_stable", out_if.vect, held);
      end
      tick();
      if (done_cnt > 0) break;
    end
    in_if.valid = 1'b0; start_i = 1'b0;
    chk("done_seen", done_cnt, 1);
    tick();
    chk("done_single", done_cnt, 1);
  endtask

  task automatic check_row(input int len, input logic [VW-1:0] strb, input int row);
    int nb, ecnt;
    logic [VW-1:0] es;
    nb = (len + VW - 1) / VW;
    ecnt = 0;
    chk("n_beats", oq_vect.size(), nb);
    chk("n_accepted", acc_cnt, nb);
    for (int b = 0; b < nb; b++) begin
      for (int k = 0; k < VW; k++) begin
        es[k] = strb[k] && (b * VW + k < len);
        if (es[k]) ecnt++;
      end
      if (b < oq_vect.size()) begin
        chk($sformatf("r%0d_b%0d_vect", row, b), oq_vect[b], beat_data(row, b));
        chk($sformatf("r%0d_b%0d_strb", row, b), oq_strb[b], es);
        chk($sformatf("r%0d_b%0d_last", row, b), oq_last[b], (b == nb - 1));
      end
    end
    chk("elem_cnt", elem_cnt_o, ecnt);
    if (oq_cyc.size() > 0) chk("done_latency", done_cyc, oq_cyc[oq_cyc.size()-1] + 1);
    chk("idle_after", busy_o, 1'b0);
  endtask

  initial begin
    rst_i = 1'b1; clear_i = 1'b0; start_i = 1'b0; length_i = '0;
    in_if.valid = 1'b0; in_if.vect = '0; in_if.strb = '0; out_if.ready = 1'b1;
    clear_mon();
    repeat (3) tick();
    chk("rst_busy", busy_o, 1'b0);
    chk("rst_done", done_o, 1'b0);
    chk("rst_in_ready", in_if.ready, 1'b0);
    chk("rst_out_valid", out_if.valid, 1'b0);
    chk("rst_out_last", out_last_o, 1'b0);
    chk("rst_out_strb", out_if.strb, 4'b0000);
    chk("rst_out_vect", out_if.vect, 128'h0);
    chk("rst_elem_cnt", elem_cnt_o, 16'd0);
    rst_i = 1'b0;
    tick();

    run_row(10, 4'b1111, 1, 0, 0);
    check_row(10, 4'b1111, 1);

    run_row(8, 4'b1010, 2, 0, 0);
    check_row(8, 4'b1010, 2);

    run_row(12, 4'b1111, 3, 0, 6);
    check_row(12, 4'b1111, 3);
    if (oq_cyc.size() == 3) chk("back_to_back", oq_cyc[2] - oq_cyc[0], 2);

    // Zero-length row goes straight to DONE.
    clear_mon();
    start_i = 1'b1; length_i = 16'd0; in_if.valid = 1'b1; out_if.ready = 1'b1;
    tick();
    start_i = 1'b0;
    chk("len0_busy", busy_o, 1'b1);
    chk("len0_done", done_o, 1'b1);
    tick();
    chk("len0_busy_end", busy_o, 1'b0);
    repeat (3) tick();
    chk("len0_busy_cycles", busy_cnt, 1);
    chk("len0_done_cnt", done_cnt, 1);
    chk("len0_no_accept", acc_cnt, 0);
    in_if.valid = 1'b0;

    // Clear after the first accepted beat of a 3-beat row.
    clear_mon();
    start_i = 1'b1; length_i = 16'd12;
    tick();
    start_i = 1'b0;
    for (int it = 0; it < 20 && acc_cnt < 1; it++) begin
      in_if.valid = 1'b1; in_if.vect = beat_data(4, acc_cnt); in_if.strb = 4'b1111;
      tick();
    end
    chk("clr_one_accepted", acc_cnt, 1);
    in_if.valid = 1'b0; clear_i = 1'b1;
    tick();
    clear_i = 1'b0;
    chk("clr_busy", busy_o, 1'b0);
    chk("clr_out_valid", out_if.valid, 1'b0);
    chk("clr_elem_cnt", elem_cnt_o, 16'd0);
    repeat (3) tick();
    chk("clr_no_done", done_cnt, 0);
    run_row(4, 4'b1111, 5, 0, 0);
    check_row(4, 4'b1111, 5);

    // Restart pulse during RUN must not alter framing.
    run_row(10, 4'b1111, 6, 4, 0);
    check_row(10, 4'b1111, 6);

    $display("test done: total=%0d bad=%0d", n_chk, n_bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout got=%0d exp=0", cyc);
    $fatal(1, "timeout");
  end
endmodule

// File: doc/softex_fp_vect_framer.md
Name: softex_fp_vect_framer

Overview:
- Upstream feeder of the global min/max tracker and the softmax accumulation datapath.
- Takes raw VECT_WIDTH-lane FP beats from the streamer and frames them into one softmax row of length_i elements.
- Masks lanes past the end of the row, tags the final beat, and counts forwarded elements.
- Buffers beats in a 2-entry FIFO so the downstream ready_o does not combinationally reach the streamer.

Parameters:
- FPFORMAT, FPFORMAT_IN: FP format of the elements.
- WIDTH, fpnew_pkg::fp_width(FPFORMAT): element width (localparam).
- VECT_WIDTH, 1: lanes per beat.
- LEN_WIDTH, 16: width of the row-length and element counters.

Ports:
- clk_i  in  1  clock.
- rst_i  in  1  synchronous reset, active-high.
- clear_i  in  1  synchronous soft clear; same effect as rst_i.
- start_i  in  1  start a row; sampled only in IDLE.
- length_i  in  LEN_WIDTH  row length in elements; sampled with start_i.
- busy_o  out  1  high when state is not IDLE.
- done_o  out  1  one-cycle pulse when the row is fully delivered.
- in_valid_i  in  1  input beat valid.
- in_ready_o  out  1  input beat accepted when in_valid_i & in_ready_o.
- in_vect_i  in  VECT_WIDTH*WIDTH  input lanes; lane 0 = first element.
- in_strb_i  in  VECT_WIDTH  input lane strobes.
- out_valid_o  out  1  FIFO head valid.
- out_ready_i  in  1  downstream ready.
- out_vect_o  out  VECT_WIDTH*WIDTH  output lanes.
- out_strb_o  out  VECT_WIDTH  masked strobes.
- out_last_o  out  1  head beat is the last beat of the row.
- elem_cnt_o  out  LEN_WIDTH  number of strobed elements forwarded in the current row.

Behaviour:
- Reset and clear:
  - rst_i has priority over clear_i; clear_i has priority over all other events.
  - Both force state to IDLE, empty the FIFO, rem_q=0 and elem_cnt_o=0.
  - No done_o is produced, including when asserted mid-row.
  - Reset values of outputs: busy_o=0, done_o=0, in_ready_o=0, out_valid_o=0, out_last_o=0, out_strb_o=0, out_vect_o=0, elem_cnt_o=0.
- FSM, states IDLE / RUN / DRAIN / DONE:
  - IDLE: start_i with length_i!=0 loads rem_q=length_i, clears elem_cnt, goes to RUN.
  - IDLE: start_i with length_i==0 goes directly to DONE; no beat is accepted.
  - RUN: in_ready_o = ~fifo_full. On each accepted beat:
    - n = min(rem_q, VECT_WIDTH).
    - out strobe lane k = in_strb_i[k] & (k<n).
    - last = (rem_q <= VECT_WIDTH).
    - rem_q -= n. Lanes are counted positionally, regardless of strobes.
    - elem_cnt += popcount(masked strobes), saturating at all-ones.
    - Push {vect, masked strb, last} into the FIFO.
    - Accepting the last beat moves the FSM to DRAIN.
  - DRAIN: in_ready_o=0. When the FIFO head with last=1 handshakes on the output, go to DONE.
  - DONE: done_o=1 for exactly one cycle, then IDLE.
  - start_i in any state other than IDLE is ignored.
- FIFO:
  - 2 entries, registered outputs.
  - Beat accepted in cycle t is visible on out_valid_o in cycle t+1 at the earliest.
  - Push and pop in the same cycle with occupancy 1 keeps occupancy 1, giving a sustained 1 beat/cycle when out_ready_i=1.
  - While full, in_ready_o=0.
  - Head outputs hold stable while out_valid_o=1 & ~out_ready_i.
  - Beats with an all-zero masked strobe are still forwarded.
- in_ready_o depends only on registered state and FIFO occupancy, never on in_valid_i or out_ready_i.
- Input beats in IDLE, DRAIN and DONE are not accepted and not consumed.

Test Plan:
- VECT_WIDTH=4, length 10, all strobes 1, out_ready_i=1 -> 3 output beats with strb 1111, 1111, 0011; out_last_o only on beat 3; elem_cnt_o=10; done_o pulses 1 cycle after beat-3 handshake.
- length 8, in_strb_i=1010 on every beat -> 2 beats with strb 1010, 1010; last on beat 2; elem_cnt_o=4.
- Continuous input with out_ready_i held 0 -> exactly 2 beats accepted, then in_ready_o=0. Release ready -> head data unchanged until its handshake; 1 beat/cycle thereafter.
- start_i with length_i=0 -> busy_o high 1 cycle, done_o pulse, no in_ready_o.
- clear_i after 1 of 3 beats -> next cycle IDLE, out_valid_o=0, no done_o. A new start with length 4 -> one beat, strb 1111, last=1.
- start_i pulsed again during RUN with a different length -> ignored; the original row framing completes unchanged.
